fsm_seq16_scheduler: RTL and testbench



---
 rtl/fsm_seq16_scheduler.sv | 166 ++++++++++++++++
 tb/tb_fsm_seq16_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq16_scheduler.sv
// Dwell-time scheduler driving a 16-state sequential sequencer FSM.
// Optional single-step control is enabled by defining FSM_SEQ16_STEP_EN.
module fsm_seq16_scheduler #(
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we_i,
    input  logic [3:0]    cfg_addr_i,
    input  logic [DW-1:0] cfg_data_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [LW-1:0] loops_i,
    input  logic [3:0]    st_i,
`ifdef FSM_SEQ16_STEP_EN
    input  logic          step_mode_i,
    input  logic          step_i,
`endif
    output logic [15:0]   t_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [LW-1:0] loop_cnt_o
);

    localparam int unsigned NST = 16;
    localparam int unsigned IW  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   loops_q, loops_d;
    logic [LW-1:0]   loop_cnt_q, loop_cnt_d;
    logic [NST-1:0]  t_q, t_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dwell_q [NST];

    logic [IW-1:0]   idx_nxt;
    logic [LW-1:0]   loop_inc;
    logic            fire_ok_c;

    // Permission to leave COUNT once the dwell has expired
`ifdef FSM_SEQ16_STEP_EN
    assign fire_ok_c = !step_mode_i || step_i;
`else
    assign fire_ok_c = 1'b1;
`endif

    assign idx_nxt  = idx_q + IW'(1);
    assign loop_inc = loop_cnt_q + LW'(1);

    // Dwell table: a write and a same-edge load of that entry sees the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NST; k++) begin
                dwell_q[k] <= '0;
            end
        end else if (cfg_we_i) begin
            dwell_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            loops_q    <= '0;
            loop_cnt_q <= '0;
            t_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            loops_q    <= loops_d;
            loop_cnt_q <= loop_cnt_d;
            t_q        <= t_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and registered-output decode; abort outranks the mismatch check
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        loops_d    = loops_q;
        loop_cnt_d = loop_cnt_q;
        t_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i && (st_i == '0)) begin
                    state_d    = COUNT;
                    idx_d      = '0;
                    cnt_d      = dwell_q[0];
                    loop_cnt_d = '0;
                    loops_d    = loops_i;
                end
            end
            COUNT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (st_i != idx_q) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    if (fire_ok_c) begin
                        state_d = FIRE;
                        t_d     = NST'(1) << idx_q;
                    end
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            FIRE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (st_i != idx_q) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = COUNT;
                    idx_d   = idx_nxt;
                    cnt_d   = dwell_q[idx_nxt];
                    if (idx_q == IW'(NST - 1)) begin
                        loop_cnt_d = loop_inc;
                        if ((loops_q != '0) && (loop_inc == loops_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign t_o        = t_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign loop_cnt_o = loop_cnt_q;

endmodule

// File: tb/tb_fsm_seq16_scheduler.sv
// Bench for fsm_seq16_scheduler: table-driven runs, hand sequences for abort,
// mismatch, live reconfiguration and async reset, then randomized stimulus.
module tb_fsm_seq16_scheduler;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic          abort;
    logic [LW-1:0] loops;
    logic [3:0]    st;
`ifdef FSM_SEQ16_STEP_EN
    logic          step_mode;
    logic          step;
`endif
    logic [15:0]   t;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] loop_cnt;

    always #5 clk = ~clk;

    fsm_seq16_scheduler #(.DW(DW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .start_i    (start),
        .abort_i    (abort),
        .loops_i    (loops),
        .st_i       (st),
`ifdef FSM_SEQ16_STEP_EN
        .step_mode_i(step_mode),
        .step_i     (step),
`endif
        .t_o        (t),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .loop_cnt_o (loop_cnt)
    );

    // Reference model: a run is a walk through states k with a period of dwell+2
    // cycles; pos counts cycles spent in the current period, the pulse is its last.
    int m_tbl [16];
    bit m_run;
    int m_k, m_d, m_pos, m_tgt, m_lc;
    bit m_done, m_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_t();
        logic [15:0] one;
        one = 16'h0001;
        return (m_run && (m_pos == m_d + 1)) ? (one << m_k) : 16'h0000;
    endfunction

    function automatic bit step_hold();
`ifdef FSM_SEQ16_STEP_EN
        return step_mode && !step;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        m_run = 0; m_k = 0; m_d = 0; m_pos = 0; m_tgt = 0; m_lc = 0;
        m_done = 0; m_err = 0;
        for (int k = 0; k < 16; k++) m_tbl[k] = 0;
    endtask

    // Advance the model across one clock edge using the inputs about to be sampled
    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (!m_run) begin
            if (start && !abort && st == 4'd0) begin
                m_run = 1; m_k = 0; m_d = m_tbl[0]; m_pos = 0; m_lc = 0;
                m_tgt = int'(loops);
            end
        end else if (abort) begin
            m_run = 0;
        end else if (int'(st) != m_k) begin
            m_run = 0;
            m_err = 1;
        end else if (m_pos == m_d + 1) begin
            if (m_k == 15) begin
                m_lc = (m_lc + 1) % 256;
                if (m_tgt != 0 && m_lc == m_tgt) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
            m_k   = (m_k + 1) % 16;
            m_d   = m_tbl[m_k];
            m_pos = 0;
        end else if (!(m_pos == m_d && step_hold())) begin
            m_pos++;
        end
        if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
    endtask

    // One clock: sequencer follows t, model advances, all outputs compared
    task automatic tick();
        logic [3:0] st_n;
        st_n = (t[st] === 1'b1) ? st + 4'd1 : st;
        model_step();
        @(posedge clk);
        #1;
        st = st_n;
        cyc++;
        @(negedge clk);
        chk("outs", 32'({t, busy, done, err, loop_cnt}),
            32'({exp_t(), m_run, m_done, m_err, LW'(m_lc)}));
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        start = 0; abort = 0; loops = 0;
`ifdef FSM_SEQ16_STEP_EN
        step_mode = 0; step = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        st = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic program_all(input int val, input int sp_idx, input int sp_val);
        for (int k = 0; k < 16; k++) begin
            cfg_we   = 1;
            cfg_addr = 4'(k);
            cfg_data = DW'((k == sp_idx) ? sp_val : val);
            tick();
        end
        cfg_we = 0;
    endtask

    task automatic wait_st(input logic [3:0] s);
        int n;
        n = 0;
        while (st != s && n < 400) begin
            tick();
            n++;
        end
        chk("wait_st", 32'(st), 32'(s));
    endtask

    task automatic start_run(input int lp);
        st    = 0;
        loops = LW'(lp);
        start = 1;
        tick();
        start = 0;
    endtask

    typedef struct {
        int dw_all;
        int sp_idx;
        int sp_val;
        int lp;
        int exp_done_cyc;
        int exp_lc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, pulses, sp_cnt, len, done_seen;
        idle_inputs();
        st = 0;
        do_reset();
        chk("reset_outs", 32'({t, busy, done, err, loop_cnt}), 32'(0));

        // done cycle counted from the start edge = 1 + loops * sum(dwell+2)
        vecs[0] = '{0, 3, 0, 1, 33, 1};
        vecs[1] = '{0, 3, 5, 1, 38, 1};
        vecs[2] = '{1, 4, 1, 1, 49, 1};
        vecs[3] = '{0, 15, 2, 2, 69, 2};
        vecs[4] = '{2, 9, 0, 1, 63, 1};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            program_all(vecs[i].dw_all, vecs[i].sp_idx, vecs[i].sp_val);
            start_run(vecs[i].lp);
            n = 1; pulses = 0; sp_cnt = 0;
            while (!done && n < 1000) begin
                if (t != 16'h0) pulses++;
                if (st == 4'(vecs[i].sp_idx)) sp_cnt++;
                if (i == 0 && n >= 2 && n <= 32 && (n % 2) == 0)
                    chk("t_pos", 32'(t), 32'(1) << ((n - 2) / 2));
                tick();
                n++;
            end
            chk("done_cyc", 32'(n), 32'(vecs[i].exp_done_cyc));
            chk("done_busy", 32'({done, busy}), 32'(2'b10));
            chk("done_lc", 32'(loop_cnt), 32'(vecs[i].exp_lc));
            chk("t_pulses", 32'(pulses), 32'(16 * vecs[i].lp));
            chk("sp_len", 32'(sp_cnt), 32'(vecs[i].lp * (vecs[i].sp_val + 2)));
            tick();
            chk("done_pulse", 32'(done), 32'(0));
        end

        // Forever run with a live rewrite of a later state's dwell
        do_reset();
        start_run(0);
        wait_st(4'd2);
        cfg_we = 1; cfg_addr = 4'd7; cfg_data = DW'(3);
        tick();
        cfg_we = 0;
        wait_st(4'd7);
        len = 0;
        while (st == 4'd7 && len < 50) begin
            tick();
            len++;
        end
        chk("st7_len", 32'(len), 32'(5));
        n = 0; done_seen = 0;
        while (loop_cnt != LW'(2) && n < 300) begin
            tick();
            if (done) done_seen = 1;
            n++;
        end
        chk("forever_lc", 32'(loop_cnt), 32'(2));
        chk("forever_nodone", 32'(done_seen), 32'(0));
        chk("forever_busy", 32'(busy), 32'(1));
        abort = 1;
        tick();
        abort = 0;

        // Abort mid-COUNT of state 5, then a start with st!=0 is ignored
        do_reset();
        program_all(4, 0, 4);
        start_run(1);
        wait_st(4'd5);
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_outs", 32'({t, busy, done, err}), 32'(0));
        chk("abort_st", 32'(st), 32'(5));
        start = 1; loops = LW'(1);
        tick();
        start = 0;
        chk("ign_start", 32'({busy, err}), 32'(0));
        tick();
        chk("ign_start2", 32'(busy), 32'(0));

        // Sequencer reset during state 6 of the second loop
        do_reset();
        program_all(3, 0, 3);
        start_run(3);
        n = 0;
        while (!(loop_cnt == LW'(1) && st == 4'd6) && n < 400) begin
            tick();
            n++;
        end
        tick();
        st = 4'd0;
        tick();
        chk("mm_outs", 32'({t, busy, done, err}), 32'(1));
        chk("mm_lc", 32'(loop_cnt), 32'(1));
        tick();
        chk("mm_pulse", 32'(err), 32'(0));

        // Asynchronous reset while a transition request is on the wire
        do_reset();
        start_run(1);
        n = 0;
        while (t == 16'h0 && n < 20) begin
            tick();
            n++;
        end
        chk("pre_rst_t", 32'(t != 16'h0), 32'(1));
        #2;
        rst = 1;
        #1;
        chk("async_rst", 32'({t, busy, loop_cnt}), 32'(0));
        idle_inputs();
        st = 0;
        model_clear();
        @(negedge clk);
        rst = 0;

`ifdef FSM_SEQ16_STEP_EN
        // Single-step: the pulse follows a step by one cycle, early steps are ignored
        do_reset();
        cfg_we = 1; cfg_addr = 4'd1; cfg_data = DW'(2);
        tick();
        cfg_we = 0;
        step_mode = 1;
        start_run(1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("step_hold", 32'({t, busy}), 32'(1));
        end
        step = 1;
        tick();
        step = 0;
        chk("step_fire0", 32'(t), 32'(16'h0001));
        tick();
        step = 1;
        tick();
        step = 0;
        chk("step_early", 32'(t), 32'(0));
        for (int k = 0; k < 4; k++) tick();
        chk("step_wait", 32'(t), 32'(0));
        step = 1;
        tick();
        step = 0;
        chk("step_fire1", 32'(t), 32'(16'h0002));
        abort = 1;
        tick();
        abort = 0;
        step_mode = 0;
`endif

        // Randomized traffic with the model checking every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            abort    = ($urandom_range(0, 249) == 0);
            loops    = LW'($urandom_range(0, 2));
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 4'($urandom);
            cfg_data = DW'($urandom_range(0, 3));
`ifdef FSM_SEQ16_STEP_EN
            step_mode = ($urandom_range(0, 9) == 0);
            step      = ($urandom_range(0, 1) == 0);
`endif
            if ($urandom_range(0, 299) == 0)
                st = 4'($urandom);
            else if (!busy && $urandom_range(0, 2) == 0)
                st = 4'd0;
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
